load_store_unit: RTL and testbench

- Initiator side of the word-addressed synchronous data memory. Sits in the MEM stage of the MIPS pipeline.
- Accepts byte-addressed load/store requests of byte, halfword or word size.
- Drives the memory's Address/WriteData/MemWrite/MemRead. Returns sign- or zero-extended load data.
- Sub-word stores are done as read-modify-write. The pipeline is stalled while the unit is busy.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed synchronous data memory.
// Sub-word stores are performed as read-modify-write; the pipeline stalls while busy.
module load_store_unit #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  ReqValid,
   input  logic                  ReqWrite,
   input  logic [1:0]            ReqSize,
   input  logic                  ReqUnsigned,
   input  logic [31:0]           ReqAddr,
   input  logic [31:0]           ReqWData,
   output logic                  Ready,
   output logic                  Stall,
   output logic                  Done,
   output logic                  Err,
   output logic [31:0]           LoadData,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic [31:0]           MemWriteData,
   output logic                  MemWrite,
   output logic                  MemRead,
   input  logic [31:0]           MemReadData
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      RESP  = 3'd2,
      MERGE = 3'd3,
      WR    = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_t state_reg, state_next;

   logic                  write_reg;
   logic [1:0]            size_reg;
   logic                  unsigned_reg;
   logic [1:0]            offset_reg;
   logic [15:0]           wdata_reg;
   logic [ADDR_WIDTH-1:0] mem_address_reg;
   logic [31:0]           mem_write_data_reg;
   logic                  mem_write_reg;
   logic                  mem_read_reg;
   logic [31:0]           load_data_reg;

   logic                  accept;
   logic                  req_bad;
   logic                  req_word_store;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [31:0]           load_value;
   logic [31:0]           merged_word;
   logic [3:0]            lane_hit;
   logic                  unused_addr_bits;

   // Byte addresses wrap: bits above the word-address field are don't-care.
   assign unused_addr_bits = ^ReqAddr[31:ADDR_WIDTH+2];

   assign accept         = (state_reg == IDLE) && ReqValid;
   assign req_word_store = ReqWrite && (ReqSize == SIZE_WORD);

   always_comb begin
      req_bad = 1'b0;
      case (ReqSize)
         SIZE_BYTE: req_bad = 1'b0;
         SIZE_HALF: req_bad = ReqAddr[0];
         SIZE_WORD: req_bad = (ReqAddr[1:0] != 2'b00);
         default:   req_bad = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (req_bad)
                  state_next = ERR;
               else if (req_word_store)
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD:      state_next = write_reg ? MERGE : RESP;
         RESP:    state_next = IDLE;
         MERGE:   state_next = WR;
         WR:      state_next = DONE;
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Little-endian lane extraction from the word the memory returns in RESP.
   assign byte_sel = MemReadData[{offset_reg, 3'b000} +: 8];
   assign half_sel = offset_reg[1] ? MemReadData[31:16] : MemReadData[15:0];

   always_comb begin
      load_value = MemReadData;
      case (size_reg)
         SIZE_BYTE: load_value = {{24{~unsigned_reg & byte_sel[7]}}, byte_sel};
         SIZE_HALF: load_value = {{16{~unsigned_reg & half_sel[15]}}, half_sel};
         default:   load_value = MemReadData;
      endcase
   end

   // Odd lanes of a halfword store take the upper store byte, all others the lower.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_hit[gi] = (size_reg == SIZE_BYTE) ? (offset_reg == 2'(gi))
                                                       : (offset_reg[1] == gi[1]);
         assign merged_word[8*gi +: 8] =
            !lane_hit[gi]                              ? MemReadData[8*gi +: 8] :
            ((size_reg == SIZE_HALF) && (gi % 2 == 1)) ? wdata_reg[15:8] :
                                                         wdata_reg[7:0];
      end
   endgenerate

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg          <= IDLE;
         write_reg          <= 1'b0;
         size_reg           <= 2'b00;
         unsigned_reg       <= 1'b0;
         offset_reg         <= 2'b00;
         wdata_reg          <= 16'h0000;
         mem_address_reg    <= '0;
         mem_write_data_reg <= 32'h0000_0000;
         mem_write_reg      <= 1'b0;
         mem_read_reg       <= 1'b0;
         load_data_reg      <= 32'h0000_0000;
      end else begin
         state_reg     <= state_next;
         mem_read_reg  <= (state_next == RD);
         mem_write_reg <= (state_next == WR);
         if (accept && !req_bad) begin
            write_reg       <= ReqWrite;
            size_reg        <= ReqSize;
            unsigned_reg    <= ReqUnsigned;
            offset_reg      <= ReqAddr[1:0];
            wdata_reg       <= ReqWData[15:0];
            mem_address_reg <= ReqAddr[ADDR_WIDTH+1:2];
            if (req_word_store)
               mem_write_data_reg <= ReqWData;
         end
         if (state_reg == MERGE)
            mem_write_data_reg <= merged_word;
         if (state_reg == RESP)
            load_data_reg <= load_value;
      end
   end

   assign Ready        = (state_reg == IDLE);
   assign Stall        = ~Ready;
   assign Done         = (state_reg == RESP) || (state_reg == DONE) || (state_reg == ERR);
   assign Err          = (state_reg == ERR);
   // The fresh result is forwarded in the RESP cycle, then held in the register.
   assign LoadData     = (state_reg == RESP) ? load_value : load_data_reg;
   assign MemAddress   = mem_address_reg;
   assign MemWriteData = mem_write_data_reg;
   assign MemWrite     = mem_write_reg;
   assign MemRead      = mem_read_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases, reset
// abort cases and randomized traffic checked against a word-array model.
module tb_load_store_unit;

   logic        Clk;
   logic        Rst_n;
   logic        ReqValid;
   logic        ReqWrite;
   logic [1:0]  ReqSize;
   logic        ReqUnsigned;
   logic [31:0] ReqAddr;
   logic [31:0] ReqWData;
   logic        Ready;
   logic        Stall;
   logic        Done;
   logic        Err;
   logic [31:0] LoadData;
   logic [9:0]  MemAddress;
   logic [31:0] MemWriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] MemReadData;

   load_store_unit #(.ADDR_WIDTH(10)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
      .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr),
      .ReqWData(ReqWData), .Ready(Ready), .Stall(Stall), .Done(Done), .Err(Err),
      .LoadData(LoadData), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Synchronous data memory with a backdoor port for preloading.
   logic [31:0] sim_mem [0:1023];
   logic        bk_we;
   logic [9:0]  bk_addr;
   logic [31:0] bk_data;

   always @(posedge Clk) begin
      if (MemWrite)
         sim_mem[MemAddress] <= MemWriteData;
      else if (bk_we)
         sim_mem[bk_addr] <= bk_data;
      MemReadData <= sim_mem[MemAddress];
   end

   logic [31:0] ref_mem [0:1023];
   logic [31:0] load_model;
   int vectors;
   int miscompares;

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge Clk);
      bk_we = 1'b1; bk_addr = 10'(idx); bk_data = val;
      ref_mem[idx] = val;
      @(negedge Clk);
      bk_we = 1'b0;
   endtask

   task automatic run_txn(input logic w, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] ld_obs);
      int idx, off, exp_lat, exp_rd_mask, exp_wr_mask, rd_mask, wr_mask, cyc;
      bit bad, seen_done, err_obs;
      logic [31:0] old_w, new_w, exp_ld;
      idx = int'(a[11:2]);
      off = int'(a[1:0]);
      bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0);
      old_w = ref_mem[idx];
      new_w = old_w;
      exp_ld = load_model;
      if (!bad && w) begin
         if (sz == 2'd0)      new_w = (old_w & ~(32'hFF << (8*off)))   | ((wd & 32'hFF)   << (8*off));
         else if (sz == 2'd1) new_w = (old_w & ~(32'hFFFF << (8*off))) | ((wd & 32'hFFFF) << (8*off));
         else                 new_w = wd;
      end else if (!bad) begin
         if (sz == 2'd0) begin
            exp_ld = (old_w >> (8*off)) & 32'hFF;
            if (!un && exp_ld[7]) exp_ld = exp_ld | 32'hFFFF_FF00;
         end else if (sz == 2'd1) begin
            exp_ld = (old_w >> (8*off)) & 32'hFFFF;
            if (!un && exp_ld[15]) exp_ld = exp_ld | 32'hFFFF_0000;
         end else begin
            exp_ld = old_w;
         end
      end
      exp_lat     = bad ? 1 : (w && sz != 2'd2) ? 4 : 2;
      exp_rd_mask = (bad || (w && sz == 2'd2)) ? 0 : 2;
      exp_wr_mask = (bad || !w) ? 0 : (sz == 2'd2) ? 2 : 8;

      @(negedge Clk);
      vectors++;
      if (Ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_idle: got %b want 1", Ready);
      end
      ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqUnsigned = un;
      ReqAddr = a; ReqWData = wd;
      @(posedge Clk);
      @(negedge Clk);
      // Busy-time garbage on the request port must be ignored.
      ReqValid = 1'($urandom); ReqWrite = 1'($urandom); ReqSize = 2'($urandom);
      ReqUnsigned = 1'($urandom); ReqAddr = $urandom; ReqWData = $urandom;
      seen_done = 0; rd_mask = 0; wr_mask = 0; cyc = 0; err_obs = 0; ld_obs = 32'h0;
      for (int c = 1; c <= 8 && !seen_done; c++) begin
         if (c > 1) @(negedge Clk);
         cyc = c;
         if (MemRead === 1'b1) begin
            rd_mask |= (1 << c);
            vectors++;
            if (MemAddress !== 10'(idx)) begin
               miscompares++;
               $display("FAIL rd_addr: got %0d want %0d", MemAddress, idx);
            end
         end
         if (MemWrite === 1'b1) begin
            wr_mask |= (1 << c);
            vectors++;
            if (MemAddress !== 10'(idx) || MemWriteData !== new_w) begin
               miscompares++;
               $display("FAIL wr_word: got addr %0d data %h want addr %0d data %h",
                        MemAddress, MemWriteData, idx, new_w);
            end
         end
         vectors++;
         if (Stall !== ~Ready) begin
            miscompares++;
            $display("FAIL stall: got %b want %b", Stall, ~Ready);
         end
         if (Done === 1'b1) begin
            seen_done = 1; err_obs = Err; ld_obs = LoadData;
            ReqValid = 1'b0;
         end
      end
      ReqValid = 1'b0;
      vectors++;
      if (!seen_done || cyc != exp_lat) begin
         miscompares++;
         $display("FAIL latency: got %0d (done=%0d) want %0d", cyc, seen_done, exp_lat);
      end
      vectors++;
      if (err_obs !== bad) begin
         miscompares++;
         $display("FAIL err: got %b want %b", err_obs, bad);
      end
      vectors++;
      if (ld_obs !== exp_ld) begin
         miscompares++;
         $display("FAIL load_data: got %h want %h", ld_obs, exp_ld);
      end
      vectors++;
      if (rd_mask != exp_rd_mask || wr_mask != exp_wr_mask) begin
         miscompares++;
         $display("FAIL strobes: got rd %h wr %h want rd %h wr %h",
                  rd_mask, wr_mask, exp_rd_mask, exp_wr_mask);
      end
      ref_mem[idx] = new_w;
      load_model = exp_ld;
      @(negedge Clk);
      vectors++;
      if (sim_mem[idx] !== new_w || LoadData !== exp_ld) begin
         miscompares++;
         $display("FAIL mem_hold: got word %h ld %h want word %h ld %h",
                  sim_mem[idx], LoadData, new_w, exp_ld);
      end
      $display("txn w=%0d size=%0d uns=%0d addr=%h wdata=%h -> done@%0d err=%0d ld=%h",
               w, sz, un, a, wd, cyc, err_obs, ld_obs);
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      if ({Ready, Stall, Done, Err, MemWrite, MemRead} !== 6'b100000 ||
          LoadData !== 32'h0 || MemAddress !== 10'h0 || MemWriteData !== 32'h0) begin
         miscompares++;
         $display("FAIL %s: got rdy%b stl%b dn%b er%b mw%b mr%b ld %h ma %h md %h want 1 0 0 0 0 0 all zero",
                  tag, Ready, Stall, Done, Err, MemWrite, MemRead, LoadData, MemAddress, MemWriteData);
      end
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_state");
      repeat (2) @(negedge Clk);
      check_reset_outputs("reset_held");
      Rst_n = 1'b1;
      load_model = 32'h0;
   endtask

   task automatic test_directed();
      logic [31:0] ld;
      preload(5, 32'h8899_AABB);
      run_txn(0, 2'd2, 0, 32'h14, 32'h0, ld);
      vectors++; if (ld !== 32'h8899_AABB) begin miscompares++; $display("FAIL plan_lw: got %h want 8899aabb", ld); end
      run_txn(0, 2'd0, 0, 32'h17, 32'h0, ld);
      vectors++; if (ld !== 32'hFFFF_FF88) begin miscompares++; $display("FAIL plan_lb: got %h want ffffff88", ld); end
      run_txn(0, 2'd0, 1, 32'h17, 32'h0, ld);
      vectors++; if (ld !== 32'h0000_0088) begin miscompares++; $display("FAIL plan_lbu: got %h want 00000088", ld); end
      run_txn(0, 2'd1, 0, 32'h16, 32'h0, ld);
      vectors++; if (ld !== 32'hFFFF_8899) begin miscompares++; $display("FAIL plan_lh: got %h want ffff8899", ld); end
      run_txn(0, 2'd1, 1, 32'h14, 32'h0, ld);
      vectors++; if (ld !== 32'h0000_AABB) begin miscompares++; $display("FAIL plan_lhu: got %h want 0000aabb", ld); end
      run_txn(1, 2'd0, 0, 32'h15, 32'h0000_00CD, ld);
      run_txn(0, 2'd2, 0, 32'h14, 32'h0, ld);
      vectors++; if (ld !== 32'h8899_CDBB) begin miscompares++; $display("FAIL plan_sb: got %h want 8899cdbb", ld); end
      run_txn(1, 2'd2, 0, 32'h0FFC, 32'hDEAD_BEEF, ld);
      run_txn(0, 2'd2, 0, 32'h1FFC, 32'h0, ld);
      vectors++; if (ld !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL plan_wrap: got %h want deadbeef", ld); end
      run_txn(0, 2'd1, 0, 32'h15, 32'h0, ld);
      run_txn(1, 2'd3, 0, 32'h0, 32'h1234_5678, ld);
      vectors++; if (LoadData !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL plan_err_hold: got %h want deadbeef", LoadData); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] ld;
      bit wrote;
      preload(5, 32'h8899_AABB);
      preload(0, 32'h0102_0304);
      @(negedge Clk);
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqUnsigned = 1'b0;
      ReqAddr = 32'h14; ReqWData = 32'h11;
      @(posedge Clk);
      @(negedge Clk);
      ReqValid = 1'b0;
      wrote = (MemWrite === 1'b1);
      @(negedge Clk);
      wrote = wrote || (MemWrite === 1'b1);
      Rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_in_merge");
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         wrote = wrote || (MemWrite === 1'b1);
         vectors++;
         if (Done !== 1'b0) begin miscompares++; $display("FAIL reset_no_done: got %b want 0", Done); end
      end
      Rst_n = 1'b1;
      load_model = 32'h0;
      vectors++;
      if (wrote || sim_mem[5] !== 32'h8899_AABB) begin
         miscompares++;
         $display("FAIL reset_merge_mem: got wrote=%0d word %h want 0 8899aabb", wrote, sim_mem[5]);
      end
      // Cut a word-store WR cycle: MemWrite must drop at once and nothing lands.
      @(negedge Clk);
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd2; ReqAddr = 32'h0; ReqWData = 32'hCAFE_F00D;
      @(posedge Clk);
      @(negedge Clk);
      ReqValid = 1'b0;
      vectors++;
      if (MemWrite !== 1'b1) begin miscompares++; $display("FAIL wr_before_reset: got %b want 1", MemWrite); end
      Rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_in_wr");
      @(negedge Clk);
      Rst_n = 1'b1;
      vectors++;
      if (sim_mem[0] !== 32'h0102_0304) begin miscompares++; $display("FAIL reset_wr_mem: got %h want 01020304", sim_mem[0]); end
      run_txn(0, 2'd2, 0, 32'h14, 32'h0, ld);
   endtask

   task automatic test_random();
      logic [31:0] ld, a;
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      for (int n = 0; n < 150; n++) begin
         a = $urandom;
         a[11:6] = 6'd0;
         run_txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, ld);
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0; ReqUnsigned = 1'b0;
      ReqAddr = 32'h0; ReqWData = 32'h0;
      bk_we = 1'b0; bk_addr = 10'h0; bk_data = 32'h0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      load_model = 32'h0;
      test_reset();
      test_directed();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
